// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and ring entry type for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DROP_W = 8;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [INSN_W-1:0] instruction_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    instruction_t      word;
    logic              filled;
  } ring_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order alloc/fill/read ring for fetched instructions; flush empties it in one cycle.
module fetch_ring
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_alloc,
  input  logic [ADDR_W-1:0]  i_alloc_pc,
  input  logic               i_fill,
  input  instruction_t       i_fill_word,
  input  logic               i_rd,
  output logic [PTR_W-1:0]   o_used,
  output logic [PTR_W-1:0]   o_pending,
  output logic               o_head_valid,
  output logic [ADDR_W-1:0]  o_head_pc,
  output instruction_t       o_head_word
);

  localparam int unsigned IDX_W = PTR_W - 1;

  ring_entry_t       r_ent [DEPTH];
  logic [PTR_W-1:0]  r_alloc;
  logic [PTR_W-1:0]  r_fill;
  logic [PTR_W-1:0]  r_rd;
  logic [IDX_W-1:0]  w_alloc_idx;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_alloc_idx = r_alloc[IDX_W-1:0];
  assign w_fill_idx  = r_fill[IDX_W-1:0];
  assign w_rd_idx    = r_rd[IDX_W-1:0];

  // Pointers carry a wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_rd    <= '0;
    end else if (i_flush) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_rd    <= '0;
    end else begin
      if (i_alloc) r_alloc <= r_alloc + PTR_W'(1);
      if (i_fill)  r_fill  <= r_fill + PTR_W'(1);
      if (i_rd)    r_rd    <= r_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ent[i].filled <= FALSE;
    end else begin
      if (i_alloc) r_ent[w_alloc_idx].pc <= i_alloc_pc;
      if (i_fill) begin
        r_ent[w_fill_idx].word   <= i_fill_word;
        r_ent[w_fill_idx].filled <= TRUE;
      end
      if (i_rd) r_ent[w_rd_idx].filled <= FALSE;
    end
  end

  assign o_used       = r_alloc - r_rd;
  assign o_pending    = r_alloc - r_fill;
  assign o_head_valid = r_ent[w_rd_idx].filled;
  assign o_head_pc    = r_ent[w_rd_idx].pc;
  assign o_head_word  = r_ent[w_rd_idx].word;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/response, redirect flush and drop counting.
// Optional misaligned-redirect fault guarded by FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [ADDR_W-1:0]  o_imem_req_addr,
  input  logic               i_imem_rsp_valid,
  input  instruction_t       i_imem_rsp_data,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_insn_valid,
  input  logic               i_insn_ready,
  output instruction_t       o_insn,
  output logic [ADDR_W-1:0]  o_insn_pc,
  output logic               o_misalign_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [PTR_W-1:0]  w_used;
  logic [PTR_W-1:0]  w_pending;
  logic              w_fault;
  logic              w_req_fire;
  logic              w_rsp_keep;
  logic              w_rd_fire;
  logic              w_head_valid;
  logic [ADDR_W-1:0] w_target;

  assign o_imem_req_valid = rst_n && (w_used < PTR_W'(DEPTH)) && !i_redirect_valid && !w_fault;
  assign o_imem_req_addr  = r_pc;
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;
  assign w_rsp_keep       = i_imem_rsp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
  assign w_rd_fire        = w_head_valid && i_insn_ready;
  assign o_insn_valid     = w_head_valid;
  assign w_target         = {i_redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_pc <= w_target;
    end else if (w_req_fire) begin
      r_pc <= r_pc + PC_INC;
    end
  end

  // Responses for requests issued before a flush are counted off and discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (i_redirect_valid) begin
      r_drop_cnt <= r_drop_cnt + DROP_W'(w_pending) - DROP_W'(i_imem_rsp_valid);
    end else if (i_imem_rsp_valid && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - DROP_W'(1);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= FALSE;
    end else if (i_redirect_valid) begin
      r_misalign <= (i_redirect_pc[1:0] != 2'b00);
    end
  end

  assign w_fault = r_misalign;
`else
  logic w_unused_lsb;

  assign w_unused_lsb = ^i_redirect_pc[1:0];
  assign w_fault      = FALSE;
`endif

  assign o_misalign_fault = w_fault;

  fetch_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (i_redirect_valid),
    .i_alloc      (w_req_fire),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_rsp_keep),
    .i_fill_word  (i_imem_rsp_data),
    .i_rd         (w_rd_fire),
    .o_used       (w_used),
    .o_pending    (w_pending),
    .o_head_valid (w_head_valid),
    .o_head_pc    (o_insn_pc),
    .o_head_word  (o_insn)
  );

endmodule
